fft_seq_ctrl: RTL and testbench

Parametrised in-place radix-2 DIT FFT sequencer. It replaces the fixed 512-point control cluster (MCU, address generator, timers, twiddle index counter) with one FSM. It generates single-port SRAM read/write addresses and enables, butterfly capture and output-select strobes, twiddle ROM index, stage count and done pulse for any power-of-two size. New over the previous generation:
- inverse-FFT mode via a twiddle-conjugate flag
- SRAM grant back-pressure
- configurable butterfly pipeline latency

---
 rtl/fft_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 DIT FFT sequencer: one FSM drives SRAM addresses/enables, butterfly
// capture/select strobes, twiddle index and stage count for an N = 2**LOG2N point transform.
module fft_seq_ctrl #(
    parameter int unsigned LOG2N    = 9,
    parameter int unsigned BFLY_LAT = 2,
    parameter int unsigned STG_W    = $clog2(LOG2N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fft_start,
    input  logic               inverse,
    input  logic               mem_gnt,
    output logic               sram_read_ena,
    output logic               sram_write_ena,
    output logic [LOG2N-1:0]   sram_addr,
    output logic               cap_a,
    output logic               cap_b,
    output logic               out_sel,
    output logic [LOG2N-2:0]   twiddle_index,
    output logic               twiddle_conj,
    output logic [STG_W-1:0]   stage_count,
    output logic               busy,
    output logic               fft_done
);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWait,
        StWrA,
        StWrB,
        StDone
    } state_t;

    localparam logic [LOG2N-2:0] JLast    = '1;
    localparam logic [STG_W-1:0] SLast    = STG_W'(LOG2N - 1);
    localparam logic [3:0]       WaitLast = 4'(BFLY_LAT - 1);

    state_t           state_q, state_d;
    logic [LOG2N-2:0] j_q, j_d;
    logic [STG_W-1:0] s_q, s_d;
    logic [3:0]       wait_q, wait_d;
    logic             conj_q, conj_d;
    logic             cap_a_q, cap_b_q;

    // pos_mask selects the low s bits of j (the position inside a butterfly group)
    logic [LOG2N-2:0] pos_mask;
    logic [LOG2N-2:0] pos;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [STG_W-1:0] tw_shift;

    always_comb begin
        pos_mask = ~({(LOG2N - 1){1'b1}} << s_q);
        pos      = j_q & pos_mask;
        span     = LOG2N'(1) << s_q;
        addr_a   = {j_q & ~pos_mask, 1'b0} | {1'b0, pos};
        addr_b   = addr_a | span;
        tw_shift = SLast - s_q;
    end

    always_comb begin
        state_d        = state_q;
        j_d            = j_q;
        s_d            = s_q;
        wait_d         = wait_q;
        conj_d         = conj_q;
        sram_read_ena  = 1'b0;
        sram_write_ena = 1'b0;
        sram_addr      = '0;
        out_sel        = 1'b0;
        fft_done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fft_start) begin
                    conj_d  = inverse;
                    j_d     = '0;
                    s_d     = '0;
                    state_d = StRdA;
                end
            end
            StRdA: begin
                sram_read_ena = 1'b1;
                sram_addr     = addr_a;
                if (mem_gnt) state_d = StRdB;
            end
            StRdB: begin
                sram_read_ena = 1'b1;
                sram_addr     = addr_b;
                if (mem_gnt) begin
                    wait_d  = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (wait_q == WaitLast) state_d = StWrA;
                else                    wait_d  = wait_q + 4'd1;
            end
            StWrA: begin
                sram_write_ena = 1'b1;
                sram_addr      = addr_a;
                if (mem_gnt) state_d = StWrB;
            end
            StWrB: begin
                sram_write_ena = 1'b1;
                sram_addr      = addr_b;
                out_sel        = 1'b1;
                if (mem_gnt) begin
                    if (j_q != JLast) begin
                        j_d     = j_q + (LOG2N - 1)'(1);
                        state_d = StRdA;
                    end else if (s_q != SLast) begin
                        j_d     = '0;
                        s_d     = s_q + STG_W'(1);
                        state_d = StRdA;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                fft_done = 1'b1;
                j_d      = '0;
                s_d      = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            j_q     <= '0;
            s_q     <= '0;
            wait_q  <= '0;
            conj_q  <= 1'b0;
            cap_a_q <= 1'b0;
            cap_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            s_q     <= s_d;
            wait_q  <= wait_d;
            conj_q  <= conj_d;
            // read data arrives one cycle after a granted read
            cap_a_q <= (state_q == StRdA) && mem_gnt;
            cap_b_q <= (state_q == StRdB) && mem_gnt;
        end
    end

    assign cap_a         = cap_a_q;
    assign cap_b         = cap_b_q;
    assign twiddle_index = pos << tw_shift;
    assign twiddle_conj  = conj_q;
    assign stage_count   = s_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: an 8-point instance under varied grant/start/reset
// stimulus and a 512-point instance run once at full grant.
module tb_fft_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-point instance
    logic       rst, fft_start, inverse, mem_gnt;
    logic       re3, we3, cap_a3, cap_b3, sel3, conj3, busy3, done3;
    logic [2:0] addr3;
    logic [1:0] tw3, stg3;

    // 512-point instance
    logic       rst9, start9, inv9, gnt9;
    logic       re9, we9, cap_a9, cap_b9, sel9, conj9, busy9, done9;
    logic [8:0] addr9;
    logic [7:0] tw9;
    logic [3:0] stg9;

    fft_seq_ctrl #(.LOG2N(3), .BFLY_LAT(2)) u_dut3 (
        .clk(clk), .rst(rst), .fft_start(fft_start), .inverse(inverse), .mem_gnt(mem_gnt),
        .sram_read_ena(re3), .sram_write_ena(we3), .sram_addr(addr3), .cap_a(cap_a3),
        .cap_b(cap_b3), .out_sel(sel3), .twiddle_index(tw3), .twiddle_conj(conj3),
        .stage_count(stg3), .busy(busy3), .fft_done(done3)
    );

    fft_seq_ctrl #(.LOG2N(9), .BFLY_LAT(1)) u_dut9 (
        .clk(clk), .rst(rst9), .fft_start(start9), .inverse(inv9), .mem_gnt(gnt9),
        .sram_read_ena(re9), .sram_write_ena(we9), .sram_addr(addr9), .cap_a(cap_a9),
        .cap_b(cap_b9), .out_sel(sel9), .twiddle_index(tw9), .twiddle_conj(conj9),
        .stage_count(stg9), .busy(busy9), .fft_done(done9)
    );

    typedef struct packed {
        logic        wr;
        logic        sel;
        logic [15:0] addr;
        logic [15:0] tw;
        logic [7:0]  stg;
    } xfer_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    xfer_t q3[$];
    xfer_t q9[$];
    int    lat3[$];
    int    gnt_mode = 0;
    int    stall_b = 0;
    int    stall_w = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic xfer_t mk(bit wr, bit sel, int addr, int tw, int stg);
        xfer_t x;
        x.wr   = wr;
        x.sel  = sel;
        x.addr = 16'(addr);
        x.tw   = 16'(tw);
        x.stg  = 8'(stg);
        return x;
    endfunction

    // Textbook DIT schedule: groups of 2*half, butterflies (g+k, g+k+half), twiddle k*N/(2*half)
    task automatic gen_sched(input int lg);
        int n;
        n = 1 << lg;
        for (int s = 0; s < lg; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < n; g += 2 * half) begin
                for (int k = 0; k < half; k++) begin
                    int a, b, tw;
                    a  = g + k;
                    b  = a + half;
                    tw = k * (n / (2 * half));
                    if (lg == 9) begin
                        q9.push_back(mk(0, 0, a, tw, s));
                        q9.push_back(mk(0, 0, b, tw, s));
                        q9.push_back(mk(1, 0, a, tw, s));
                        q9.push_back(mk(1, 1, b, tw, s));
                    end else begin
                        q3.push_back(mk(0, 0, a, tw, s));
                        q3.push_back(mk(0, 0, b, tw, s));
                        q3.push_back(mk(1, 0, a, tw, s));
                        q3.push_back(mk(1, 1, b, tw, s));
                    end
                end
            end
        end
    endtask

    task automatic cmp_xfer(input string tag, input xfer_t act, input xfer_t exp);
        check({tag, "_wr"},    act.wr,   exp.wr);
        check({tag, "_sel"},   act.sel,  exp.sel);
        check({tag, "_addr"},  act.addr, exp.addr);
        check({tag, "_tw"},    act.tw,   exp.tw);
        check({tag, "_stage"}, act.stg,  exp.stg);
    endtask

    // Grant driver: always granted, a fixed stall on the first RD_B/WR_A, or random
    initial begin
        mem_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: begin
                    if (re3 && stg3 == 2'd0 && addr3 == 3'd1 && stall_b < 3) begin
                        mem_gnt = 1'b0;
                        stall_b++;
                    end else if (we3 && !sel3 && stg3 == 2'd0 && addr3 == 3'd0 && stall_w < 2) begin
                        mem_gnt = 1'b0;
                        stall_w++;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
                default: mem_gnt = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor for the 8-point instance
    bit         p_stall, p_rda_g, p_rdb_g, rd_phase, exp_conj, first_rd_pend, post_done;
    logic [4:0] p_bus;
    int         t0, l3;
    xfer_t      act3;

    always @(negedge clk) begin
        if (rst) begin
            p_stall = 0; p_rda_g = 0; p_rdb_g = 0; rd_phase = 0;
            exp_conj = 0; first_rd_pend = 0; post_done = 0;
        end else begin
            check("rd_wr_excl", re3 && we3, 0);
            if (p_stall) check("stall_hold", {re3, we3, addr3}, p_bus);
            if (cap_a3 || p_rda_g) check("cap_a", cap_a3, p_rda_g);
            if (cap_b3 || p_rdb_g) check("cap_b", cap_b3, p_rdb_g);
            if (busy3) check("twiddle_conj", conj3, exp_conj);
            if (post_done) begin
                check("busy_after_done", busy3, 0);
                post_done = 0;
            end
            if (first_rd_pend && re3) begin
                check("first_rd_a_cycle", cyc - t0, 1);
                first_rd_pend = 0;
            end
            p_rda_g = 0;
            p_rdb_g = 0;
            if ((re3 || we3) && mem_gnt) begin
                act3 = mk(we3, sel3, int'(addr3), int'(tw3), int'(stg3));
                if (q3.size() == 0) check("xfer_unexpected", 1, 0);
                else cmp_xfer("xfer", act3, q3.pop_front());
                if (re3) begin
                    if (!rd_phase) p_rda_g = 1;
                    else           p_rdb_g = 1;
                    rd_phase = ~rd_phase;
                end
            end
            p_stall = (re3 || we3) && !mem_gnt;
            p_bus   = {re3, we3, addr3};
            if (!busy3 && fft_start) begin
                t0 = cyc;
                exp_conj = inverse;
                first_rd_pend = 1;
            end
            if (done3) begin
                if (lat3.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    l3 = lat3.pop_front();
                    if (l3 >= 0) check("done_cycle", cyc - t0, l3);
                end
                post_done = 1;
            end
        end
    end

    // Monitor for the 512-point instance
    bit    rd9_phase, done9_seen;
    int    t9, bf9, ra9, lb_a, lb_b, lb_tw, lb_s;
    xfer_t act9;

    always @(negedge clk) begin
        if (!rst9) begin
            check("rd_wr_excl9", re9 && we9, 0);
            if (!busy9 && start9) t9 = cyc;
            if ((re9 || we9) && gnt9) begin
                act9 = mk(we9, sel9, int'(addr9), int'(tw9), int'(stg9));
                if (q9.size() == 0) check("xfer9_unexpected", 1, 0);
                else cmp_xfer("xfer9", act9, q9.pop_front());
                if (re9) begin
                    if (!rd9_phase) ra9 = int'(addr9);
                    rd9_phase = ~rd9_phase;
                end
                if (we9 && sel9) begin
                    bf9++;
                    lb_a = ra9; lb_b = int'(addr9); lb_tw = int'(tw9); lb_s = int'(stg9);
                end
            end
            if (done9) begin
                check("done9_cycle", cyc - t9, 11521);
                check("bfly9_count", bf9, 2304);
                check("last_bfly_a", lb_a, 255);
                check("last_bfly_b", lb_b, 511);
                check("last_bfly_tw", lb_tw, 255);
                check("last_bfly_stage", lb_s, 8);
                check("sched9_left", q9.size(), 0);
                done9_seen = 1;
            end
        end
    end

    task automatic start_run(input bit inv, input int mode, input int lat);
        gnt_mode = mode;
        gen_sched(3);
        lat3.push_back(lat);
        @(posedge clk);
        #1;
        fft_start = 1'b1;
        inverse   = inv;
        @(posedge clk);
        #1;
        fft_start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done3) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n, dc;
        rst = 1'b1; fft_start = 1'b0; inverse = 1'b0;
        rst9 = 1'b1; start9 = 1'b0; inv9 = 1'b0; gnt9 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst9 = 1'b0;
        @(negedge clk);
        check("reset_outputs", {re3, we3, addr3, cap_a3, cap_b3, sel3, tw3, conj3, stg3,
                                busy3, done3}, 0);

        // 512-point run proceeds alongside the 8-point scenarios
        gen_sched(9);
        @(posedge clk);
        #1;
        start9 = 1'b1;
        @(posedge clk);
        #1;
        start9 = 1'b0;

        // full grant
        start_run(0, 0, 73);
        wait_done();

        // fixed stalls: 3 cycles in first RD_B, 2 in first WR_A
        stall_b = 0;
        stall_w = 0;
        start_run(0, 1, 78);
        wait_done();

        // inverse latched at start, dropped mid-run, random grant
        start_run(1, 2, -1);
        repeat (20) @(posedge clk);
        #1;
        inverse = 1'b0;
        wait_done();

        // reset in the first WAIT of stage 1
        start_run(1, 0, -1);
        n = 0;
        @(negedge clk);
        while (!(stg3 == 2'd1 && cap_b3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(stg3 == 2'd1 && cap_b3)) check("stage1_wait_timeout", 0, 1);
        q3.delete();
        lat3.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {re3, we3, addr3, cap_a3, cap_b3, sel3, tw3, conj3, stg3,
                                busy3, done3}, 0);
        start_run(0, 0, 73);
        wait_done();

        // start pulses while busy, then start held through DONE
        start_run(0, 0, 73);
        n = 0;
        while (stg3 != 2'd2 && n < 500) begin
            @(posedge clk);
            #1;
            fft_start = 1'($urandom_range(0, 1));
            n++;
        end
        gen_sched(3);
        lat3.push_back(73);
        fft_start = 1'b1;
        wait_done();
        dc = cyc;
        n = 0;
        @(negedge clk);
        while (!re3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("restart_gap", cyc - dc, 2);
        @(posedge clk);
        #1;
        fft_start = 1'b0;
        wait_done();

        n = 0;
        while (!done9_seen && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done9_seen) check("done9_timeout", 0, 1);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
